// File: rtl/riscv_core_div_ctrl.sv
// Issue/sequencing controller for the RV64 M-extension divider: one request in flight, special cases answered in 1 cycle.
// Normal ops launch riscv_core_div and hold its result until writeback takes it; rvalid holds under backpressure.
module riscv_core_div_ctrl #(
  parameter int XLEN    = 64,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 80
) (
  input  logic             i_divctl_clk,
  input  logic             i_divctl_rst,
  input  logic             i_divctl_flush,
  input  logic             i_divctl_valid,
  output logic             o_divctl_ready,
  input  logic [XLEN-1:0]  i_divctl_srcA,
  input  logic [XLEN-1:0]  i_divctl_srcB,
  input  logic [1:0]       i_divctl_control,
  input  logic             i_divctl_isword,
  input  logic [TAG_W-1:0] i_divctl_tag,
  output logic [XLEN-1:0]  o_divctl_div_srcA,
  output logic [XLEN-1:0]  o_divctl_div_srcB,
  output logic [1:0]       o_divctl_div_control,
  output logic             o_divctl_div_isword,
  output logic             o_divctl_div_en,
  input  logic             i_divctl_div_done,
  input  logic [XLEN-1:0]  i_divctl_div_result,
  output logic             o_divctl_rvalid,
  input  logic             i_divctl_rready,
  output logic [XLEN-1:0]  o_divctl_result,
  output logic [TAG_W-1:0] o_divctl_rtag,
  output logic             o_divctl_dbz,
  output logic             o_divctl_ovf,
  output logic             o_divctl_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  opa_q, opb_q;
  logic [1:0]       ctrl_q;
  logic             isword_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  res_q;
  logic             dbz_q, ovf_q, err_q;

  logic             accept;
  logic             b_zero, ovf_hit, special;
  logic [XLEN-1:0]  a_sext32, spec_res;
  logic             load_div, timeout;

  assign o_divctl_ready = (state_q == S_IDLE) & ~i_divctl_flush & ~i_divctl_rst;
  assign accept         = i_divctl_valid & o_divctl_ready;

  // W-forms only look at the low word; the upper halves of both operands are don't-care.
  assign b_zero  = i_divctl_isword ? (i_divctl_srcB[31:0] == 32'h0)
                                   : (i_divctl_srcB == '0);
  assign ovf_hit = ~i_divctl_control[0] &
                   (i_divctl_isword
                     ? ((i_divctl_srcA[31:0] == 32'h8000_0000) && (i_divctl_srcB[31:0] == 32'hFFFF_FFFF))
                     : ((i_divctl_srcA == {1'b1, {(XLEN-1){1'b0}}}) && (i_divctl_srcB == {XLEN{1'b1}})));
  assign special  = b_zero | ovf_hit;
  assign a_sext32 = {{(XLEN-32){i_divctl_srcA[31]}}, i_divctl_srcA[31:0]};

  always_comb begin
    spec_res = '0;
    if (b_zero) begin
      if (i_divctl_control[1]) spec_res = i_divctl_isword ? a_sext32 : i_divctl_srcA;
      else                     spec_res = '1;
    end else if (ovf_hit) begin
      if (!i_divctl_control[1]) spec_res = i_divctl_isword ? {{(XLEN-32){1'b1}}, 32'h8000_0000}
                                                           : i_divctl_srcA;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_div = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = special ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        state_d = i_divctl_flush ? S_DRAIN : S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A flush racing with done simply drops the result; nothing is left to drain.
        if (i_divctl_flush) begin
          state_d = i_divctl_div_done ? S_IDLE : S_DRAIN;
          cnt_d   = '0;
        end else if (i_divctl_div_done) begin
          load_div = 1'b1;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (i_divctl_div_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (i_divctl_flush || i_divctl_rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_divctl_clk) begin
    if (i_divctl_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      ctrl_q   <= '0;
      isword_q <= 1'b0;
      tag_q    <= '0;
      res_q    <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Operand registers only change on accept, so they stay stable for the whole divider run.
      if (accept) begin
        opa_q    <= i_divctl_srcA;
        opb_q    <= i_divctl_srcB;
        ctrl_q   <= i_divctl_control;
        isword_q <= i_divctl_isword;
        tag_q    <= i_divctl_tag;
      end
      if (accept && special) begin
        res_q <= spec_res;
        dbz_q <= b_zero;
        ovf_q <= ~b_zero & ovf_hit;
      end else if (load_div) begin
        res_q <= i_divctl_div_result;
        dbz_q <= 1'b0;
        ovf_q <= 1'b0;
      end
      if (timeout) err_q <= 1'b1;
    end
  end

  assign o_divctl_div_srcA    = opa_q;
  assign o_divctl_div_srcB    = opb_q;
  assign o_divctl_div_control = ctrl_q;
  assign o_divctl_div_isword  = isword_q;
  assign o_divctl_div_en      = (state_q == S_ISSUE);
  assign o_divctl_rvalid      = (state_q == S_RESP);
  assign o_divctl_result      = res_q;
  assign o_divctl_rtag        = tag_q;
  assign o_divctl_dbz         = dbz_q;
  assign o_divctl_ovf         = ovf_q;
  assign o_divctl_err         = err_q;

endmodule

// File: tb/tb_riscv_core_div_ctrl.sv
// Directed bench for riscv_core_div_ctrl with a fixed-latency divider model (4 cycles div_en -> done).
module tb_riscv_core_div_ctrl;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst, flush, valid, ready;
  logic [63:0] srcA, srcB;
  logic [1:0]  ctrl;
  logic        isword;
  logic [4:0]  tag;
  logic [63:0] div_a, div_b;
  logic [1:0]  div_ctrl;
  logic        div_w, div_en, div_done;
  logic [63:0] div_res;
  logic        rvalid, rready;
  logic [63:0] result;
  logic [4:0]  rtag;
  logic        dbz, ovf, err;

  logic        hang;
  int          dcnt;
  int          en_cnt;
  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  riscv_core_div_ctrl #(.XLEN(64), .TAG_W(5), .TIMEOUT(80)) dut (
    .i_divctl_clk        (clk),
    .i_divctl_rst        (rst),
    .i_divctl_flush      (flush),
    .i_divctl_valid      (valid),
    .o_divctl_ready      (ready),
    .i_divctl_srcA       (srcA),
    .i_divctl_srcB       (srcB),
    .i_divctl_control    (ctrl),
    .i_divctl_isword     (isword),
    .i_divctl_tag        (tag),
    .o_divctl_div_srcA   (div_a),
    .o_divctl_div_srcB   (div_b),
    .o_divctl_div_control(div_ctrl),
    .o_divctl_div_isword (div_w),
    .o_divctl_div_en     (div_en),
    .i_divctl_div_done   (div_done),
    .i_divctl_div_result (div_res),
    .o_divctl_rvalid     (rvalid),
    .i_divctl_rready     (rready),
    .o_divctl_result     (result),
    .o_divctl_rtag       (rtag),
    .o_divctl_dbz        (dbz),
    .o_divctl_ovf        (ovf),
    .o_divctl_err        (err)
  );

  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] c, input logic w);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      case (c)
        2'b00:   r32 = $signed(a32) / $signed(b32);
        2'b01:   r32 = a32 / b32;
        2'b10:   r32 = $signed(a32) % $signed(b32);
        default: r32 = a32 % b32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (c)
        2'b00:   r = $signed(a) / $signed(b);
        2'b01:   r = a / b;
        2'b10:   r = $signed(a) % $signed(b);
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  // Divider model: done pulses L cycles after the div_en cycle unless hung.
  always @(posedge clk) begin
    if (rst) begin
      dcnt     <= 0;
      div_done <= 1'b0;
      div_res  <= '0;
      en_cnt   <= 0;
    end else begin
      div_done <= 1'b0;
      if (div_en) begin
        en_cnt  <= en_cnt + 1;
        dcnt    <= L - 1;
        div_res <= ref_div(div_a, div_b, div_ctrl, div_w);
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1 && !hang) div_done <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                       input logic w, input logic [4:0] t);
    valid  = 1'b1;
    srcA   = a;
    srcB   = b;
    ctrl   = c;
    isword = w;
    tag    = t;
    step();
    valid  = 1'b0;
  endtask

  task automatic handshake();
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    int base;
    int cyc;
    logic seen;

    rst = 1'b1; flush = 1'b0; valid = 1'b0; srcA = '0; srcB = '0;
    ctrl = 2'b00; isword = 1'b0; tag = '0; rready = 1'b0; hang = 1'b0;
    repeat (2) step();
    check("rst_ready",  64'(ready),  64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_div_en", 64'(div_en), 64'd0);
    check("rst_err",    64'(err),    64'd0);
    check("rst_result", result,      64'd0);
    check("rst_div_a",  div_a,       64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(ready), 64'd1);

    // DIVU 100/7
    issue(64'd100, 64'd7, 2'b01, 1'b0, 5'd3);
    base = en_cnt;
    check("divu_en",     64'(div_en),   64'd1);
    check("divu_opA",    div_a,         64'd100);
    check("divu_opB",    div_b,         64'd7);
    check("divu_ctrl",   64'(div_ctrl), 64'd1);
    check("divu_rv_n1",  64'(rvalid),   64'd0);
    repeat (L) step();
    check("divu_rv_done", 64'(rvalid),  64'd0);
    step();
    check("divu_rvalid", 64'(rvalid),   64'd1);
    check("divu_result", result,        64'h0E);
    check("divu_dbz",    64'(dbz),      64'd0);
    check("divu_ovf",    64'(ovf),      64'd0);
    check("divu_tag",    64'(rtag),     64'd3);
    check("divu_en_cnt", 64'(en_cnt - base), 64'd1);
    handshake();
    check("divu_rv_clr", 64'(rvalid),   64'd0);
    check("divu_ready",  64'(ready),    64'd1);

    // DIVW / REMW divide by zero
    issue(64'h0000_0001_0000_0005, 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 5'd7);
    check("divw_dbz_rv",  64'(rvalid), 64'd1);
    check("divw_dbz_res", result,      64'hFFFF_FFFF_FFFF_FFFF);
    check("divw_dbz_flg", 64'(dbz),    64'd1);
    check("divw_dbz_ovf", 64'(ovf),    64'd0);
    check("divw_dbz_en",  64'(div_en), 64'd0);
    check("divw_dbz_tag", 64'(rtag),   64'd7);
    handshake();
    issue(64'h0000_0001_0000_0005, 64'hFFFF_FFFF_0000_0000, 2'b10, 1'b1, 5'd8);
    check("remw_dbz_res", result,      64'h0000_0000_0000_0005);
    check("remw_dbz_flg", 64'(dbz),    64'd1);
    handshake();

    // Signed overflow
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 5'd9);
    check("div_ovf_rv",  64'(rvalid), 64'd1);
    check("div_ovf_res", result,      64'h8000_0000_0000_0000);
    check("div_ovf_flg", 64'(ovf),    64'd1);
    check("div_ovf_dbz", 64'(dbz),    64'd0);
    handshake();
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 2'b10, 1'b1, 5'd10);
    check("remw_ovf_res", result,     64'd0);
    check("remw_ovf_flg", 64'(ovf),   64'd1);
    handshake();
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1, 5'd10);
    check("divw_ovf_res", result,     64'hFFFF_FFFF_8000_0000);
    check("divw_ovf_flg", 64'(ovf),   64'd1);
    handshake();

    // Unsigned with the same operand pattern goes to the divider
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 5'd11);
    check("divu_big_en", 64'(div_en), 64'd1);
    check("divu_big_rv", 64'(rvalid), 64'd0);
    repeat (L + 1) step();
    check("divu_big_rv2", 64'(rvalid), 64'd1);
    check("divu_big_res", result,      64'd0);
    check("divu_big_ovf", 64'(ovf),    64'd0);
    handshake();

    // REM -7 % 2 under backpressure
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'b10, 1'b0, 5'd12);
    repeat (L + 1) step();
    for (int i = 0; i < 10; i++) begin
      check("bp_rvalid", 64'(rvalid), 64'd1);
      check("bp_result", result,      64'hFFFF_FFFF_FFFF_FFFF);
      check("bp_ready",  64'(ready),  64'd0);
      step();
    end
    check("bp_tag", 64'(rtag), 64'd12);
    handshake();
    check("bp_rv_clr", 64'(rvalid), 64'd0);
    check("bp_ready2", 64'(ready),  64'd1);

    // Flush in IDLE blocks acceptance
    valid = 1'b1; flush = 1'b1; srcA = 64'd9; srcB = 64'd3; ctrl = 2'b00; isword = 1'b0;
    #1;
    check("idle_fl_ready", 64'(ready), 64'd0);
    step();
    valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_fl_en",  64'(div_en), 64'd0);
    check("idle_fl_rv",  64'(rvalid), 64'd0);
    check("idle_fl_rdy", 64'(ready),  64'd1);

    // Flush while waiting -> DRAIN, then a clean DIV 20/4
    issue(64'd50, 64'd5, 2'b00, 1'b0, 5'd13);
    base = en_cnt;
    repeat (3) step();
    flush = 1'b1;
    #1;
    check("fl_ready_wait", 64'(ready), 64'd0);
    step();
    flush = 1'b0;
    #1;
    check("fl_drain_rdy", 64'(ready),  64'd0);
    check("fl_drain_rv",  64'(rvalid), 64'd0);
    step();
    check("fl_idle_rdy",  64'(ready),  64'd1);
    check("fl_idle_rv",   64'(rvalid), 64'd0);
    issue(64'd20, 64'd4, 2'b00, 1'b0, 5'd14);
    repeat (L + 1) step();
    check("after_fl_rv",  64'(rvalid), 64'd1);
    check("after_fl_res", result,      64'd5);
    check("after_fl_tag", 64'(rtag),   64'd14);
    check("after_fl_en",  64'(en_cnt - base), 64'd2);
    handshake();

    // Hung divider -> watchdog
    hang = 1'b1;
    issue(64'd10, 64'd3, 2'b00, 1'b0, 5'd15);
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 120 && !err; i++) begin
      if (rvalid) seen = 1'b1;
      step();
      cyc = cyc + 1;
    end
    check("wd_err",    64'(err),    64'd1);
    check("wd_cycles", 64'(cyc),    64'd82);
    check("wd_no_rv",  64'(seen),   64'd0);
    check("wd_rv",     64'(rvalid), 64'd0);
    check("wd_ready",  64'(ready),  64'd1);
    hang = 1'b0;
    issue(64'd5, 64'd0, 2'b01, 1'b0, 5'd1);
    check("wd_sticky",  64'(err),   64'd1);
    check("post_wd_res", result,    64'hFFFF_FFFF_FFFF_FFFF);
    handshake();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("wd_rst_clr", 64'(err),   64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/riscv_core_div_ctrl.md
# riscv_core_div_ctrl

Issue/sequencing controller sitting directly upstream of `riscv_core_div` in the RV64 M-extension execute path. It accepts one divide/remainder request at a time from the execute stage and resolves RISC-V special cases (divide-by-zero, signed overflow) locally in one cycle. All other requests are launched on the iterative divider; the controller captures its result and holds it until writeback accepts it. It also handles pipeline flushes and divider hangs.

## Interface
- `XLEN`, 64, datapath width.
- `TAG_W`, 5, destination-register tag width.
- `TIMEOUT`, 80, max cycles in WAIT/DRAIN before the error path fires.

Ports:
- `i_divctl_clk` in 1: clock, rising edge.
- `i_divctl_rst` in 1: reset. **One clock; reset is synchronous and active-high.**
- `i_divctl_flush` in 1: kill the in-flight request.
- `i_divctl_valid` in 1: request valid.
- `o_divctl_ready` out 1: request can be accepted.
- `i_divctl_srcA` / `i_divctl_srcB` in XLEN: dividend / divisor.
- `i_divctl_control` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `i_divctl_isword` in 1: W-form (32-bit op, result sign-extended).
- `i_divctl_tag` in TAG_W: rd tag.
- `o_divctl_div_srcA` / `o_divctl_div_srcB` out XLEN, `o_divctl_div_control` out 2, `o_divctl_div_isword` out 1: registered operands to the divider.
- `o_divctl_div_en` out 1: one-cycle start pulse.
- `i_divctl_div_done` in 1: divider result valid (1-cycle pulse).
- `i_divctl_div_result` in XLEN: divider result.
- `o_divctl_rvalid` out 1: result valid.
- `i_divctl_rready` in 1: writeback accepts the result.
- `o_divctl_result` out XLEN, `o_divctl_rtag` out TAG_W: result and tag.
- `o_divctl_dbz` / `o_divctl_ovf` out 1: result came from the div-by-zero / overflow path.
- `o_divctl_err` out 1: sticky timeout flag, cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- `o_divctl_ready` = (state==IDLE) & ~flush & ~rst.
- **IDLE.** Accept on valid&ready. Operands, control, isword and tag are registered.
  - Special case detected: compute the result, go to RESP.
  - Otherwise: go to ISSUE.
- **Special-case detection.** Uses `[31:0]` when isword=1, the full width otherwise.
  - Div-by-zero (B==0): quotient = all ones; remainder = A (W-form: sext(A[31:0])); dbz=1.
  - Signed overflow (ctrl[0]=0, A==most-negative, B==all ones): quotient = A (W-form: sext(0x8000_0000)); remainder = 0; ovf=1.
  - Unsigned ops never flag overflow. Div-by-zero takes priority over overflow.
- **ISSUE.** `o_divctl_div_en`=1 for exactly this cycle, then go to WAIT. The divider operand outputs hold stable from ISSUE until leaving WAIT/DRAIN.
- **WAIT.** On `div_done`: capture `div_result` (W-form already sign-extended by the divider; passed through unchanged), dbz=ovf=0, go to RESP.
- **RESP.** `rvalid`=1 with result/tag/flags stable. Go to IDLE on rready.
- **Flush.**
  - IDLE: no accept, even if valid is high the same cycle.
  - ISSUE or WAIT: go to DRAIN. If `div_done` arrives in the same cycle as the flush in WAIT, go to IDLE and discard the result.
  - RESP: drop the result, go to IDLE.
- **DRAIN.** ready=0. Wait for `div_done`, discard it, go to IDLE. Flush in DRAIN has no further effect.
- **Watchdog.** The counter clears on entry to WAIT/DRAIN and increments each cycle there. On reaching TIMEOUT without done: set `o_divctl_err`, go to IDLE, no result emitted.

## Timing
- **Reset.** Sync active-high. State=IDLE; counter=0; all outputs 0 (ready=0 while rst=1, then 1 the first cycle after reset deasserts).
- **Special-case latency.** Accept in cycle N; rvalid=1 in cycle N+1.
- **Normal latency.**
  - Accept in cycle N; div_en in N+1.
  - Divider latency L cycles from div_en to done.
  - rvalid in the cycle after done (N+2+L).
- **Throughput.** One request in flight. Next accept is possible the cycle after the rready handshake.
- **Backpressure.** rvalid holds indefinitely while rready=0; result/tag/flags are unchanged.
- `o_divctl_div_en` is never asserted outside ISSUE, and never twice per request.

## Test plan
- DIVU A=100, B=7, isword=0 → div_en pulse once; result 0x0E; rvalid one cycle after done; dbz=ovf=0.
- DIVW A=0x0000_0001_0000_0005, B=0xFFFF_FFFF_0000_0000 → no div_en; result 0xFFFF_FFFF_FFFF_FFFF at N+1; dbz=1. REMW same operands → 0x0000_0000_0000_0005.
- DIV A=0x8000_0000_0000_0000, B=all ones → result 0x8000_0000_0000_0000, ovf=1. REMW A=0x8000_0000, B=0xFFFF_FFFF → result 0, ovf=1.
- REM A=-7, B=2 with rready low for 10 cycles → rvalid and result 0xFFFF_FFFF_FFFF_FFFF held stable; ready=0 throughout; accept resumes the cycle after the handshake.
- Flush 3 cycles after div_en → DRAIN; ready=0 until done; no rvalid; the following DIV 20/4 returns 5.
- Divider model never asserts done → after TIMEOUT cycles in WAIT, err=1 (sticky), state IDLE, no rvalid; reset clears err.
